// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one serial binary-to-BCD converter among N_REQ requesters.
// Optional WAIT-state abort is enabled by defining BCD_ARB_TIMEOUT_EN.
module bcd_conv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int BIN_W   = 12,
    parameter int BCD_W   = 16,
    parameter int TIMEOUT = 63
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*BIN_W-1:0] bin_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [BCD_W-1:0]       bcd_out,
    output logic                   err,
    output logic                   busy,
    output logic                   conv_en,
    output logic [BIN_W-1:0]       conv_bin,
    input  logic [BCD_W-1:0]       conv_bcd,
    input  logic                   conv_rdy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0]   NREQ_W = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_gidx;
    logic [N_REQ-1:0] r_gnt;
    logic [BCD_W-1:0] r_bcd;
    logic [BIN_W-1:0] r_conv_bin;

    logic [N_REQ-1:0] w_reqRot;
    logic             w_winValid;
    logic [PTR_W-1:0] w_off;
    logic [PTR_W:0]   w_sum;
    logic [PTR_W:0]   w_wrap;
    logic [PTR_W-1:0] w_winIdx;
    logic [BIN_W-1:0] w_winBin;
    logic             w_timeout;

    // Rotating the request vector by ptr turns "first set bit at or after ptr" into a plain
    // lowest-set-bit search; the offset is then rotated back into a requester index.
    assign w_reqRot = N_REQ'({req, req} >> r_ptr);

    always_comb begin
        w_winValid = 1'b0;
        w_off      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_reqRot[k]) begin
                w_winValid = 1'b1;
                w_off      = PTR_W'(k);
            end
        end
    end

    assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_wrap   = w_sum - NREQ_W;
    assign w_winIdx = (w_sum >= NREQ_W) ? w_wrap[PTR_W-1:0] : w_sum[PTR_W-1:0];

    always_comb begin
        w_winBin = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_winIdx == PTR_W'(k)) w_winBin = bin_in[k*BIN_W +: BIN_W];
        end
    end

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // WAIT lasts at most TIMEOUT cycles; a ready in the final cycle still wins over the abort.
    assign w_timeout = (r_state == S_WAIT) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)     r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == S_WAIT)      r_err <= w_timeout & ~conv_rdy;
        end
    end

    assign err = (r_state == S_DONE) & r_err;
`else
    logic w_unusedTimeout;

    assign w_unusedTimeout = (TIMEOUT > 0);
    assign w_timeout       = 1'b0;
    assign err             = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_gnt      <= '0;
            r_bcd      <= '0;
            r_conv_bin <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_winValid) begin
                        r_gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << w_winIdx;
                        r_gidx     <= w_winIdx;
                        r_conv_bin <= w_winBin;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (conv_rdy) begin
                        r_bcd   <= conv_bcd;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ptr   <= (r_gidx == LAST_IDX) ? '0 : r_gidx + PTR_W'(1);
                    r_gnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign done     = (r_state == S_DONE) ? r_gnt : '0;
    assign busy     = (r_state != S_IDLE);
    assign conv_en  = (r_state == S_ISSUE);
    assign conv_bin = r_conv_bin;
    assign bcd_out  = r_bcd;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter with a behavioural converter stub and arbitration model.
// Define BCD_ARB_TIMEOUT_EN for both files to also exercise the abort path.
module tb_bcd_conv_arbiter;

    localparam int N  = 4;
    localparam int BW = 12;
    localparam int CW = 16;
    localparam int TO = 63;

    typedef struct {
        int          idx;
        logic [15:0] bcd;
        logic [11:0] bin;
        bit          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*BW-1:0] bin_in;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic [CW-1:0] bcd_out;
    logic          err;
    logic          busy;
    logic          conv_en;
    logic [BW-1:0] conv_bin;
    logic [CW-1:0] conv_bcd;
    logic          conv_rdy;
    logic          rdyReal;
    logic          rdyStale;

    exp_t        expQ[$];
    logic [11:0] ops[N];
    int          mPtr = 0;
    logic [15:0] lastExp = '0;
    int          errors = 0;
    int          checks = 0;
    int          fixedLat = 0;
    int          dropIdx = -1;
    int          convCount = 0;
    bit          staleEn = 1'b0;

    always #5 clk = ~clk;

    assign conv_rdy = rdyReal | rdyStale;

    bcd_conv_arbiter #(.N_REQ(N), .BIN_W(BW), .BCD_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in), .gnt(gnt), .done(done),
        .bcd_out(bcd_out), .err(err), .busy(busy), .conv_en(conv_en), .conv_bin(conv_bin),
        .conv_bcd(conv_bcd), .conv_rdy(conv_rdy)
    );

    function automatic logic [15:0] toBcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Service order follows directly from the rule: first pending requester at or after ptr.
    task automatic predictRound(input logic [3:0] set, input bit hold, input int nComp,
                                input bit abortFirst);
        logic [3:0] rem;
        int served;
        rem    = set;
        served = 0;
        while (rem != 0 && (!hold || served < nComp)) begin
            int   w;
            exp_t e;
            w = -1;
            for (int k = 0; k < N; k++) begin
                logic [1:0] c;
                c = 2'((mPtr + k) % N);
                if (w < 0 && rem[c]) w = int'(c);
            end
            e.idx = w;
            e.bin = ops[w];
            e.err = abortFirst && (served == 0);
            e.bcd = e.err ? lastExp : toBcd(int'(ops[w]));
            lastExp = e.bcd;
            expQ.push_back(e);
            if (!hold) rem[w] = 1'b0;
            mPtr = (w + 1) % N;
            served++;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] set, input bit hold, input int nComp,
                                 input bit abortFirst);
        int comps;
        int cyc;
        comps = 0;
        cyc   = 0;
        predictRound(set, hold, nComp, abortFirst);
        @(negedge clk);
        bin_in = {ops[3], ops[2], ops[1], ops[0]};
        req    = set;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done != 0) begin
                comps++;
                if (hold) begin
                    if (comps >= nComp) req = '0;
                end else begin
                    req = req & ~done;
                end
            end else if (req == 0 && !busy) begin
                break;
            end
        end
        if (cyc >= 3000) begin
            errors++;
            checks++;
            $display("[TB] FAIL round_budget: got %0d completions, required round to finish", comps);
            req = '0;
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_gnt", 32'(gnt), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_bcd_out", 32'(bcd_out), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_conv_en", 32'(conv_en), 0);
        checkOutput("rst_conv_bin", 32'(conv_bin), 0);
    endtask

    // Converter stub: answers each start pulse after a latency, optionally never answering one.
    initial begin
        rdyReal  = 1'b0;
        conv_bcd = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (conv_en) begin
                automatic logic [11:0] v = conv_bin;
                automatic int lat = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 6));
                automatic bit drop = (convCount == dropIdx);
                convCount++;
                if (!drop) begin
                    repeat (lat) @(negedge clk);
                    rdyReal  = 1'b1;
                    conv_bcd = toBcd(int'(v));
                    @(negedge clk);
                    rdyReal  = 1'b0;
                    conv_bcd = 16'($urandom);
                end
            end
        end
    end

    initial begin
        rdyStale = 1'b0;
        forever begin
            @(negedge clk);
            rdyStale = staleEn && (conv_en || !busy);
        end
    end

    // Monitor: every done strobe is matched against the head of the expected queue.
    initial begin
        automatic int cyc = 0;
        automatic int issueCyc = 0;
        automatic logic [3:0] prevDone = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (conv_en) issueCyc = cyc;
            if (prevDone != 0) checkOutput("done_one_cycle", 32'(done), 0);
            if (done != 0) begin
                if (expQ.size() == 0) begin
                    errors++;
                    checks++;
                    $display("[TB] FAIL unexpected_done: got done=%b, required no done", done);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done", 32'(done), 32'(1) << e.idx);
                    checkOutput("gnt", 32'(gnt), 32'(1) << e.idx);
                    checkOutput("bcd_out", 32'(bcd_out), 32'(e.bcd));
                    checkOutput("conv_bin", 32'(conv_bin), 32'(e.bin));
                    checkOutput("err", 32'(err), 32'(e.err));
                    if (e.err) checkOutput("abort_latency", 32'(cyc - issueCyc), TO + 1);
                end
            end
            prevDone = done;
        end
    end

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        checkReset();
        rst_n = 1'b1;

        ops = '{12'd1, 12'd22, 12'd333, 12'd4095};
        applyStimulus(4'b1111, 1'b0, 0, 1'b0);

        ops = '{12'd0, 12'd999, 12'd0, 12'd0};
        applyStimulus(4'b0010, 1'b0, 0, 1'b0);

        for (int i = 0; i < N; i++) ops[i] = 12'($urandom_range(0, 4095));
        applyStimulus(4'b0101, 1'b1, 4, 1'b0);

        staleEn = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("stale_idle_bcd", 32'(bcd_out), 32'(lastExp));
        for (int i = 0; i < N; i++) ops[i] = 12'($urandom_range(0, 4095));
        applyStimulus(4'b1011, 1'b0, 0, 1'b0);
        repeat (4) @(negedge clk);
        staleEn = 1'b0;
        checkOutput("stale_after_bcd", 32'(bcd_out), 32'(lastExp));

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) ops[i] = 12'($urandom_range(0, 4095));
            applyStimulus(4'($urandom_range(1, 15)), 1'b0, 0, 1'b0);
        end

        // Park ptr on 2, then abort a grant to requester 3 mid-WAIT.
        ops[1] = 12'd123;
        applyStimulus(4'b0010, 1'b0, 0, 1'b0);
        fixedLat = 10;
        ops[3]   = 12'd777;
        bin_in   = {ops[3], ops[2], ops[1], ops[0]};
        req      = 4'b1000;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        #1;
        checkReset();
        expQ.delete();
        mPtr    = 0;
        lastExp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("late_rdy_bcd", 32'(bcd_out), 0);
        checkOutput("late_rdy_busy", 32'(busy), 0);
        fixedLat = 0;
        ops = '{12'd45, 12'd0, 12'd0, 12'd3210};
        applyStimulus(4'b1001, 1'b0, 0, 1'b0);

`ifdef BCD_ARB_TIMEOUT_EN
        dropIdx = convCount;
        for (int i = 0; i < N; i++) ops[i] = 12'($urandom_range(0, 4095));
        applyStimulus(4'b1100, 1'b0, 0, 1'b1);
`endif

        repeat (5) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares one serial binary-to-BCD converter among several requesters (counters, status sources) feeding the seven-segment display path. It accepts level requests with a binary operand, issues a single-cycle start pulse to the converter, waits for its ready pulse, and returns the BCD result with a one-cycle done strobe to the granted requester. Optionally it aborts conversions that never complete.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, range 2–8.
- `BIN_W`, default 12: binary operand width.
- `BCD_W`, default 16: BCD result width (4 digits).
- `TIMEOUT`, default 63: maximum WAIT cycles before abort. Used only with the timeout feature.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, N_REQ: level request per requester.
- `bin_in`, in, N_REQ*BIN_W: operands; requester i occupies bits [i*BIN_W +: BIN_W].
- `gnt`, out, N_REQ: one-hot grant, held from ISSUE through DONE.
- `done`, out, N_REQ: one-cycle completion strobe to the granted requester.
- `bcd_out`, out, BCD_W: last captured result, held until the next capture.
- `err`, out, 1: one-cycle abort strobe, coincident with `done`.
- `busy`, out, 1: high in every state except IDLE.
- `conv_en`, out, 1: converter start pulse.
- `conv_bin`, out, BIN_W: converter operand.
- `conv_bcd`, in, BCD_W: converter result.
- `conv_rdy`, in, 1: converter result-valid pulse.

## Operation
- FSM states: IDLE → ISSUE → WAIT → DONE → IDLE.
- IDLE:
  - `req` is sampled only here.
  - If any bit is set, the winner is the first set bit at or after `ptr`, searching upward with wrap.
  - Register the one-hot `gnt`, latch `conv_bin` from that requester's `bin_in` slice, go to ISSUE.
- ISSUE:
  - `conv_en`=1 for exactly this cycle, then go to WAIT.
  - `conv_rdy` seen in ISSUE is stale and ignored.
- WAIT:
  - Hold until `conv_rdy`=1.
  - Then capture `conv_bcd` into `bcd_out` and go to DONE.
- DONE:
  - `done`=`gnt` for this cycle.
  - `ptr` ← granted index + 1, modulo N_REQ.
  - Then go to IDLE; `gnt` clears on the IDLE entry.
- `conv_rdy` in IDLE or DONE is ignored and leaves `bcd_out` unchanged.
- Requester protocol:
  - Hold `req` and `bin_in` stable until `done`.
  - Deassert `req` on the edge where `done` is sampled high, otherwise it is treated as a new request.
  - `bin_in` is sampled only in the IDLE grant cycle, so later changes do not affect the running conversion.
- If the granted requester drops `req` mid-conversion, the conversion still completes: `bcd_out` updates and `done` pulses.
- Reset values: state=IDLE, `ptr`=0, `gnt`=0, `done`=0, `bcd_out`=0, `conv_bin`=0, `conv_en`=0, `busy`=0, `err`=0.
- Reset mid-operation:
  - The block returns to IDLE immediately; no `done` is issued.
  - A later `conv_rdy` from the still-running converter is ignored in IDLE.

## Timing
- Cycle 0: IDLE sees `req`.
- Cycle 1: ISSUE, `conv_en`=1, `gnt` valid.
- Cycle k: `conv_rdy`.
- Cycle k+1: DONE, `done`=1, `bcd_out` valid.
- Cycle k+2: IDLE.
- Arbiter overhead is 3 cycles beyond converter latency (26 cycles for the 12-bit serial converter).
- Back-to-back requests: the next ISSUE comes 2 cycles after DONE.

## Configuration
- `BCD_ARB_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT+1) clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT with no `conv_rdy`, go to DONE with `err`=1; `bcd_out` is not updated.
  - `done` pulses and `ptr` advances as in a normal DONE.
  - If `conv_rdy` arrives in the same cycle the count reaches TIMEOUT, `conv_rdy` wins and `err` stays 0.
- `BCD_ARB_TIMEOUT_EN` undefined:
  - WAIT is unbounded.
  - `err` is tied to 0 and no counter is built.

## Test plan
- Single request: `req`=0010, `bin_in[1]`=999 → `gnt`=0010; one `conv_en` pulse with `conv_bin`=999; `bcd_out`=16'h0999; `done`=0010 for exactly one cycle.
- All four requesters request together after reset, operands 1, 22, 333, 4095 → service order 0,1,2,3; `bcd_out` sequence 16'h0001, 16'h0022, 16'h0333, 16'h4095.
- Fairness: `req[0]` and `req[2]` held continuously → grants alternate 0,2,0,2; ≥4 completions checked with no repeats.
- Stale `conv_rdy`: inject `conv_rdy` in IDLE and in ISSUE → no `done`, `bcd_out` unchanged, FSM still completes on the real ready.
- Reset mid-conversion: assert `rst_n`=0 during WAIT → all outputs at reset values; a subsequent late `conv_rdy` is ignored; the next request is served from `ptr`=0.
- Timeout (`BCD_ARB_TIMEOUT_EN` defined): stub converter never asserts `conv_rdy` → `done` and `err` pulse TIMEOUT+1 cycles after ISSUE; `bcd_out` keeps its previous value; the next requester is then served.
